territory_ranker: RTL and testbench

Ranks the four players by territory once a round ends. It sits directly upstream of the winner-drawing sequence in the top-level control/datapath pair. On a start pulse it captures the four per-player pixel counts and sorts them with a 5-step compare-exchange network, one step per clock. It then presents `ordered_colours` (best first) with a `done_ordering` flag for the DRAW_WINNER_WAIT state to consume.

---
 rtl/tron_pkg.sv | 30 +++
 rtl/territory_ranker_if.sv | 27 ++
 rtl/rank_cmp_swap.sv | 30 +++
 rtl/territory_ranker.sv | 117 +++++++++++
 tb/tb_territory_ranker.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/tron_pkg.sv
// Shared constants, state encoding and colour lookup for the round-end
// territory ranking logic.
package tron_pkg;

    localparam int PLAYER_ID_W = 2;
    localparam int COUNT_W     = 15;

    localparam logic [2:0] COL_P1 = 3'b001;
    localparam logic [2:0] COL_P2 = 3'b010;
    localparam logic [2:0] COL_P3 = 3'b100;
    localparam logic [2:0] COL_P4 = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } rank_state_e;

    function automatic logic [2:0] id_to_colour(input logic [PLAYER_ID_W-1:0] id);
        logic [2:0] col;
        case (id)
            2'd0:    col = COL_P1;
            2'd1:    col = COL_P2;
            2'd2:    col = COL_P3;
            default: col = COL_P4;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/territory_ranker_if.sv
// Bundle of the ranking request (start + counts) and the ranking result,
// shared between the round controller and the ranker.
interface territory_ranker_if #(
    parameter int COUNT_W  = 15,
    parameter int COLOUR_W = 3
);
    logic                    start;
    logic [COUNT_W-1:0]      p1_count;
    logic [COUNT_W-1:0]      p2_count;
    logic [COUNT_W-1:0]      p3_count;
    logic [COUNT_W-1:0]      p4_count;
    logic [4*COLOUR_W-1:0]   ordered_colours;
    logic [7:0]              ranked_ids;
    logic [COUNT_W-1:0]      winner_count;
    logic                    busy;
    logic                    done_ordering;

    modport master (
        output start, p1_count, p2_count, p3_count, p4_count,
        input  ordered_colours, ranked_ids, winner_count, busy, done_ordering
    );

    modport slave (
        input  start, p1_count, p2_count, p3_count, p4_count,
        output ordered_colours, ranked_ids, winner_count, busy, done_ordering
    );
endinterface

// File: rtl/rank_cmp_swap.sv
// One compare-exchange cell: orders two (count, id) entries so the better
// ranked entry comes out first. Ties on count go to the lower player id.
module rank_cmp_swap
    import tron_pkg::*;
#(
    parameter int CNT_W = 15
) (
    input  logic [CNT_W-1:0]       lo_count_i,
    input  logic [PLAYER_ID_W-1:0] lo_id_i,
    input  logic [CNT_W-1:0]       hi_count_i,
    input  logic [PLAYER_ID_W-1:0] hi_id_i,
    output logic [CNT_W-1:0]       first_count_o,
    output logic [PLAYER_ID_W-1:0] first_id_o,
    output logic [CNT_W-1:0]       second_count_o,
    output logic [PLAYER_ID_W-1:0] second_id_o
);
    logic [CNT_W+PLAYER_ID_W-1:0] lo_key;
    logic [CNT_W+PLAYER_ID_W-1:0] hi_key;
    logic                         swap;

    // Inverting the id in the low bits makes keys unique and favours lower ids.
    assign lo_key = {lo_count_i, 2'd3 - lo_id_i};
    assign hi_key = {hi_count_i, 2'd3 - hi_id_i};
    assign swap   = hi_key > lo_key;

    assign first_count_o  = swap ? hi_count_i : lo_count_i;
    assign first_id_o     = swap ? hi_id_i    : lo_id_i;
    assign second_count_o = swap ? lo_count_i : hi_count_i;
    assign second_id_o    = swap ? lo_id_i    : hi_id_i;
endmodule

// File: rtl/territory_ranker.sv
// Captures the four player counts on start and ranks them with a 5-step
// compare-exchange network, one step per clock, reusing a single swap cell.
module territory_ranker #(
    parameter int COUNT_W  = 15,
    parameter int COLOUR_W = 3
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    territory_ranker_if.slave   bus
);
    import tron_pkg::*;

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] SORT = 2'(ST_SORT);
    localparam logic [1:0] DONE = 2'(ST_DONE);
    localparam logic [2:0] LAST_STEP = 3'd4;

    logic [1:0]             state_q, state_d;
    logic [2:0]             step_q, step_d;
    logic [COUNT_W-1:0]     cnt_q [4];
    logic [COUNT_W-1:0]     cnt_d [4];
    logic [PLAYER_ID_W-1:0] id_q  [4];
    logic [PLAYER_ID_W-1:0] id_d  [4];

    logic [1:0]             slot_lo, slot_hi;
    logic [COUNT_W-1:0]     first_count, second_count;
    logic [PLAYER_ID_W-1:0] first_id, second_id;

    always_comb begin
        slot_lo = 2'd1;
        slot_hi = 2'd2;
        case (step_q)
            3'd0:    begin slot_lo = 2'd0; slot_hi = 2'd1; end
            3'd1:    begin slot_lo = 2'd2; slot_hi = 2'd3; end
            3'd2:    begin slot_lo = 2'd0; slot_hi = 2'd2; end
            3'd3:    begin slot_lo = 2'd1; slot_hi = 2'd3; end
            default: begin slot_lo = 2'd1; slot_hi = 2'd2; end
        endcase
    end

    rank_cmp_swap #(.CNT_W(COUNT_W)) u_cmp_swap (
        .lo_count_i     (cnt_q[slot_lo]),
        .lo_id_i        (id_q[slot_lo]),
        .hi_count_i     (cnt_q[slot_hi]),
        .hi_id_i        (id_q[slot_hi]),
        .first_count_o  (first_count),
        .first_id_o     (first_id),
        .second_count_o (second_count),
        .second_id_o    (second_id)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        case (state_q)
            SORT: begin
                cnt_d[slot_lo] = first_count;
                id_d[slot_lo]  = first_id;
                cnt_d[slot_hi] = second_count;
                id_d[slot_hi]  = second_id;
                step_d         = step_q + 3'd1;
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            default: begin
                if (bus.start) begin
                    state_d  = SORT;
                    step_d   = 3'd0;
                    cnt_d[0] = bus.p1_count;
                    cnt_d[1] = bus.p2_count;
                    cnt_d[2] = bus.p3_count;
                    cnt_d[3] = bus.p4_count;
                    id_d[0]  = 2'd0;
                    id_d[1]  = 2'd1;
                    id_d[2]  = 2'd2;
                    id_d[3]  = 2'd3;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
                id_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

    // Results are only exposed while a finished ranking is held.
    always_comb begin
        bus.ordered_colours = '0;
        bus.ranked_ids      = '0;
        bus.winner_count    = '0;
        if (state_q == DONE) begin
            for (int r = 0; r < 4; r++) begin
                bus.ordered_colours[(3-r)*COLOUR_W +: COLOUR_W] = COLOUR_W'(id_to_colour(id_q[r]));
                bus.ranked_ids[(3-r)*2 +: 2] = id_q[r];
            end
            bus.winner_count = cnt_q[0];
        end
    end

    assign bus.busy          = (state_q == SORT);
    assign bus.done_ordering = (state_q == DONE);
endmodule

// File: tb/tb_territory_ranker.sv
// Directed bench for territory_ranker: stimulus pushes expected rankings into
// a scoreboard, a monitor compares them whenever done_ordering rises.
module tb_territory_ranker;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    territory_ranker_if #(.COUNT_W(15), .COLOUR_W(3)) bus ();

    territory_ranker #(.COUNT_W(15), .COLOUR_W(3)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    typedef struct {
        string       name;
        logic [11:0] col;
        logic [7:0]  ids;
        logic [14:0] win;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.done_ordering === 1'b1 && done_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(bus.ordered_colours), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check({e.name, "_colours"}, 32'(bus.ordered_colours), 32'(e.col));
                check({e.name, "_ids"},     32'(bus.ranked_ids),      32'(e.ids));
                check({e.name, "_winner"},  32'(bus.winner_count),    32'(e.win));
            end
        end
        done_prev = bus.done_ordering;
    end

    // Starts a ranking; returns at the falling edge right after E0.
    task automatic issue(input logic [14:0] c1, c2, c3, c4);
        @(negedge clk);
        bus.p1_count = c1;
        bus.p2_count = c2;
        bus.p3_count = c3;
        bus.p4_count = c4;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic push(input string name, input logic [11:0] col, input logic [7:0] ids, input logic [14:0] win);
        exp_t e;
        e.name = name;
        e.col  = col;
        e.ids  = ids;
        e.win  = win;
        sb.push_back(e);
    endtask

    task automatic check_latency(input string name);
        check({name, "_busy_e0"}, 32'(bus.busy), 32'd1);
        check({name, "_done_e0"}, 32'(bus.done_ordering), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check({name, "_done_early"}, 32'(bus.done_ordering), 32'd0);
        end
        @(posedge clk);
        #1;
        check({name, "_done_e5"}, 32'(bus.done_ordering), 32'd1);
        check({name, "_busy_e5"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_colours"}, 32'(bus.ordered_colours), 32'd0);
        check({name, "_ids"},     32'(bus.ranked_ids),      32'd0);
        check({name, "_winner"},  32'(bus.winner_count),    32'd0);
        check({name, "_busy"},    32'(bus.busy),            32'd0);
        check({name, "_done"},    32'(bus.done_ordering),   32'd0);
    endtask

    initial begin
        resetn       = 1'b0;
        bus.start    = 1'b0;
        bus.p1_count = '0;
        bus.p2_count = '0;
        bus.p3_count = '0;
        bus.p4_count = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        push("basic", 12'b010_100_110_001, 8'b01_10_11_00, 15'd400);
        issue(15'd100, 15'd400, 15'd300, 15'd200);
        check_latency("basic");

        push("all_equal", 12'b001_010_100_110, 8'b00_01_10_11, 15'd500);
        issue(15'd500, 15'd500, 15'd500, 15'd500);
        check_latency("all_equal");

        push("ties_max", 12'b010_110_001_100, 8'b01_11_00_10, 15'd32767);
        issue(15'd0, 15'd32767, 15'd0, 15'd32767);
        check_latency("ties_max");

        // Second start at E2 with new counts must be ignored.
        push("restart_ignored", 12'b010_100_110_001, 8'b01_10_11_00, 15'd400);
        issue(15'd100, 15'd400, 15'd300, 15'd200);
        @(posedge clk);
        @(negedge clk);
        bus.p1_count = 15'd7;
        bus.p2_count = 15'd6;
        bus.p3_count = 15'd5;
        bus.p4_count = 15'd4;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        check("restart_busy_e2", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("restart_done_e4", 32'(bus.done_ordering), 32'd0);
        @(posedge clk);
        #1;
        check("restart_done_e5", 32'(bus.done_ordering), 32'd1);

        // Reset at E3 of a sort.
        issue(15'd9, 15'd8, 15'd7, 15'd6);
        repeat (2) @(posedge clk);
        #1;
        check("midsort_colours_e2", 32'(bus.ordered_colours), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_zero("midsort_reset");
        @(negedge clk);
        resetn = 1'b1;
        push("after_reset", 12'b010_100_110_001, 8'b01_10_11_00, 15'd400);
        issue(15'd100, 15'd400, 15'd300, 15'd200);
        check_latency("after_reset");

        push("reversed", 12'b100_010_001_110, 8'b10_01_00_11, 15'd400);
        issue(15'd200, 15'd300, 15'd400, 15'd100);
        check_latency("reversed");

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, limit 100000", $time);
        $fatal(1);
    end

endmodule
